ibex_trace_buffer: RTL

IBEX_TRACE_BUFFER -- requirements
Module: ibex_trace_buffer

---
 rtl/ibex_pkg.sv | 47 ++++
 rtl/ibex_trace_fifo.sv | 59 +++++
 rtl/ibex_trace_buffer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the RVFI trace buffer: the captured record layout, the
// capture FSM states and the retirement filter.
package ibex_pkg;

  typedef enum logic [1:0] {
    TB_IDLE    = 2'd0,
    TB_CAPTURE = 2'd1,
    TB_HALTED  = 2'd2
  } trace_buf_state_e;

  typedef struct packed {
    logic [31:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] rd_wdata;
    logic [4:0]  rd_addr;
    logic [1:0]  mode;
    logic        trap;
    logic        intr;
    logic        gap;
  } trace_rec_t;

  localparam logic [1:0] FILT_ALL  = 2'd0;
  localparam logic [1:0] FILT_EXC  = 2'd1;
  localparam logic [1:0] FILT_PC   = 2'd2;
  localparam logic [1:0] FILT_NONE = 2'd3;

  // PC window bounds are inclusive and compared unsigned.
  function automatic logic filter_match(input logic [1:0]  mode,
                                        input logic        trap,
                                        input logic        intr,
                                        input logic [31:0] pc,
                                        input logic [31:0] pc_lo,
                                        input logic [31:0] pc_hi);
    logic m;
    m = 1'b0;
    case (mode)
      FILT_ALL:  m = 1'b1;
      FILT_EXC:  m = trap | intr;
      FILT_PC:   m = (pc >= pc_lo) && (pc <= pc_hi);
      FILT_NONE: m = 1'b0;
      default:   m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ibex_trace_fifo.sv
// Record FIFO for the trace buffer. Head record is presented directly from
// storage; a push into a full FIFO is accepted only if a pop happens too.
module ibex_trace_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 16,
  localparam int unsigned PtrW   = $clog2(Depth),
  localparam int unsigned LevelW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  trace_rec_t        wdata_i,
  input  logic              pop_i,
  output trace_rec_t        rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LevelW-1:0] level_o
);

  logic [PtrW-1:0]   wptr_q;
  logic [PtrW-1:0]   rptr_q;
  logic [LevelW-1:0] level_q;
  trace_rec_t        mem_q [Depth];

  logic do_push;
  logic do_pop;

  assign full_o  = (level_q == LevelW'(Depth));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/ibex_trace_buffer.sv
// RVFI retirement trace buffer: filters retired instructions, queues them in
// a FIFO for a slow consumer, and counts records lost to back-pressure.
module ibex_trace_buffer
  import ibex_pkg::*;
#(
  parameter int unsigned Depth        = 16,
  parameter int unsigned DropCntWidth = 16,
  parameter logic        StopOnFull   = 1'b0,
  localparam int unsigned LevelW      = $clog2(Depth + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rvfi_valid_i,
  input  logic [63:0]             rvfi_order_i,
  input  logic [31:0]             rvfi_insn_i,
  input  logic [31:0]             rvfi_pc_rdata_i,
  input  logic [31:0]             rvfi_rd_wdata_i,
  input  logic [4:0]              rvfi_rd_addr_i,
  input  logic                    rvfi_trap_i,
  input  logic                    rvfi_intr_i,
  input  logic [1:0]              rvfi_mode_i,
  input  logic                    arm_i,
  input  logic                    stop_i,
  input  logic [1:0]              filter_mode_i,
  input  logic [31:0]             pc_lo_i,
  input  logic [31:0]             pc_hi_i,
  output logic                    rec_valid_o,
  input  logic                    rec_ready_i,
  output trace_rec_t              rec_o,
  output logic [1:0]              state_o,
  output logic [LevelW-1:0]       level_o,
  output logic [DropCntWidth-1:0] drop_cnt_o
);

  trace_buf_state_e        state_q, state_d;
  logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;
  logic                    gap_pend_q, gap_pend_d;

  logic       match;
  logic       push_req;
  logic       push_acc;
  logic       drop;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  trace_rec_t wrec;
  logic       unused_order_hi;

  assign unused_order_hi = ^rvfi_order_i[63:32];

  assign match    = filter_match(filter_mode_i, rvfi_trap_i, rvfi_intr_i,
                                 rvfi_pc_rdata_i, pc_lo_i, pc_hi_i);
  assign push_req = (state_q == TB_CAPTURE) & rvfi_valid_i & match;

  // Handshake: a record transfers on any cycle where rec_valid_o and
  // rec_ready_i are both high; rec_o is held while valid waits for ready.
  assign rec_valid_o = ~fifo_empty;
  assign pop         = rec_valid_o & rec_ready_i;

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_acc = push_req & (~fifo_full | pop);
  assign drop     = push_req & fifo_full & ~pop;

  always_comb begin
    wrec          = '0;
    wrec.order    = rvfi_order_i[31:0];
    wrec.pc       = rvfi_pc_rdata_i;
    wrec.insn     = rvfi_insn_i;
    wrec.rd_wdata = rvfi_rd_wdata_i;
    wrec.rd_addr  = rvfi_rd_addr_i;
    wrec.mode     = rvfi_mode_i;
    wrec.trap     = rvfi_trap_i;
    wrec.intr     = rvfi_intr_i;
    wrec.gap      = gap_pend_q;
  end

  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    gap_pend_d = gap_pend_q;

    case (state_q)
      TB_IDLE, TB_HALTED: begin
        if (arm_i && !stop_i) begin
          state_d    = TB_CAPTURE;
          drop_cnt_d = '0;
        end
      end
      TB_CAPTURE: begin
        if (stop_i) begin
          state_d = TB_IDLE;
        end else if (drop && StopOnFull) begin
          state_d = TB_HALTED;
        end
      end
      default: state_d = TB_IDLE;
    endcase

    // Drops only happen in CAPTURE, so they never race the arm-time clear.
    if (drop) begin
      gap_pend_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end else if (push_acc) begin
      gap_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= TB_IDLE;
      drop_cnt_q <= '0;
      gap_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
      gap_pend_q <= gap_pend_d;
    end
  end

  ibex_trace_fifo #(
    .Depth(Depth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push_acc),
    .wdata_i(wrec),
    .pop_i  (pop),
    .rdata_o(rec_o),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(level_o)
  );

  assign state_o    = state_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule
